// File: rtl/ibex_pkg.sv
// Shared types for the instruction fetch FIFO: stored entry layout and depth ceiling.
package ibex_pkg;

  localparam int unsigned FETCH_FIFO_MAX_DEPTH = 8;
  localparam int unsigned FETCH_FIFO_CNT_W     = $clog2(FETCH_FIFO_MAX_DEPTH + 1);

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } fetch_entry_t;

  // Occupancy is kept as a thermometer, so the popcount is the fill level.
  function automatic logic [FETCH_FIFO_CNT_W-1:0] busy_count(
    input logic [FETCH_FIFO_MAX_DEPTH-1:0] b
  );
    logic [FETCH_FIFO_CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(FETCH_FIFO_MAX_DEPTH); i++) begin
      c = c + FETCH_FIFO_CNT_W'(b[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/ibex_fetch_fifo.sv
// Fetch FIFO with halfword realignment for compressed/unaligned instructions.
// Optional zero-latency bypass of the incoming word: define IBEX_FETCH_FIFO_BYPASS_EN.
module ibex_fetch_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic [31:0]      in_addr_i,
  input  logic             in_valid_i,
  input  logic [31:0]      in_rdata_i,
  input  logic             in_err_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_rdata_o,
  output logic [31:0]      out_addr_o,
  output logic             out_err_o,
  output logic [DEPTH-1:0] busy_o
);

  localparam int unsigned CW = FETCH_FIFO_CNT_W;

  fetch_entry_t     mem [DEPTH];
  logic [DEPTH-1:0] busy, busy_n;
  logic [31:0]      addr;

  fetch_entry_t     in_entry, head, second;
  logic             head_v, second_v;
  logic             unaligned, up_comp, compressed;
  logic             accept, pop, pop_mem, consumed, push;
  logic [CW-1:0]    count, wr_idx, count_n;

  logic             unused_addr0;
  logic             unused_second;

  assign in_entry      = '{rdata: in_rdata_i, err: in_err_i};
  assign unused_addr0  = in_addr_i[0];
  assign unused_second = ^second.rdata[31:16];

`ifdef IBEX_FETCH_FIFO_BYPASS_EN
  // Incoming word fills whichever of head/second is not yet stored.
  assign head_v   = busy[0] | in_valid_i;
  assign head     = busy[0] ? mem[0] : in_entry;
  assign second_v = busy[1] | (busy[0] & in_valid_i);
  assign second   = busy[1] ? mem[1] : in_entry;
`else
  assign head_v   = busy[0];
  assign head     = mem[0];
  assign second_v = busy[1];
  assign second   = mem[1];
`endif

  assign unaligned = addr[1];
  assign up_comp   = head.rdata[17:16] != 2'b11;

  always_comb begin
    if (!unaligned) begin
      out_valid_o = head_v;
      out_rdata_o = head.rdata;
      out_err_o   = head.err;
    end else begin
      out_valid_o = head_v & (up_comp | second_v | head.err);
      out_rdata_o = {second.rdata[15:0], head.rdata[31:16]};
      out_err_o   = head.err | (~up_comp & second_v & second.err);
    end
  end

  assign compressed = out_rdata_o[1:0] != 2'b11;
  assign accept     = out_valid_o & out_ready_i;
  // Head is released once the instruction reaches its upper halfword.
  assign pop        = accept & (unaligned | ~compressed);
  assign pop_mem    = pop & busy[0];

`ifdef IBEX_FETCH_FIFO_BYPASS_EN
  assign consumed = pop & ~busy[0];
`else
  assign consumed = 1'b0;
`endif

  assign count   = busy_count(FETCH_FIFO_MAX_DEPTH'(busy));
  assign wr_idx  = count - CW'(pop_mem);
  assign push    = in_valid_i & ~consumed & (wr_idx < CW'(DEPTH));
  assign count_n = wr_idx + CW'(push);

  always_comb begin
    busy_n = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      busy_n[i] = CW'(i) < count_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy <= '0;
      addr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (clear_i) begin
      busy <= '0;
      addr <= {in_addr_i[31:1], 1'b0};
    end else begin
      busy <= busy_n;
      if (accept) addr <= addr + (compressed ? 32'd2 : 32'd4);
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        if (pop_mem) mem[i] <= mem[i+1];
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (push && wr_idx == CW'(i)) mem[i] <= in_entry;
      end
    end
  end

  assign out_addr_o = addr;
  assign busy_o     = busy;

endmodule

// File: tb/tb_ibex_fetch_fifo.sv
// Scoreboard bench for ibex_fetch_fifo: driver queues expected instructions, monitor checks handshakes.
module tb_ibex_fetch_fifo;
  import ibex_pkg::*;

  localparam int DEPTH = 3;

  logic             clk = 1'b0;
  logic             rst, clear, in_valid, in_err, out_ready;
  logic [31:0]      in_addr, in_rdata;
  logic             out_valid, out_err;
  logic [31:0]      out_rdata, out_addr;
  logic [DEPTH-1:0] busy;

  ibex_fetch_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (clear),
    .in_addr_i   (in_addr),
    .in_valid_i  (in_valid),
    .in_rdata_i  (in_rdata),
    .in_err_i    (in_err),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_rdata_o (out_rdata),
    .out_addr_o  (out_addr),
    .out_err_o   (out_err),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] mask;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Monitor: every visible handshake consumes one expected instruction.
  always @(negedge clk) begin
    if (rst === 1'b0 && clear === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_accept: got addr %h expected no instruction", out_addr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_addr", out_addr, e.addr);
        chk("mon_rdata", out_rdata & e.mask, e.rdata);
        chk("mon_err", {31'b0, out_err}, {31'b0, e.err});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_insn(input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] m, input logic e);
    exp_t x;
    x.addr = a; x.rdata = d; x.mask = m; x.err = e;
    sb.push_back(x);
  endtask

  task automatic push(input logic [31:0] w, input logic e);
    in_valid = 1'b1; in_rdata = w; in_err = e;
    cyc();
    in_valid = 1'b0; in_err = 1'b0;
  endtask

  task automatic do_clear(input logic [31:0] a);
    clear = 1'b1; in_addr = a;
    cyc();
    clear = 1'b0;
  endtask

  task automatic accept_n(input int n);
    out_ready = 1'b1;
    repeat (n) cyc();
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_err = 1'b0; out_ready = 1'b0;
    in_addr = '0; in_rdata = '0;
    cyc(); cyc();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_addr", out_addr, 32'h0);
    chk("rst_rdata", out_rdata, 32'h0);
    chk("rst_err", {31'b0, out_err}, 32'h0);
    rst = 1'b0;
    cyc();

    // Aligned 32-bit
    do_clear(32'h80);
    push(32'h0000_0013, 1'b0);
    chk("al_valid", {31'b0, out_valid}, 32'h1);
    expect_insn(32'h80, 32'h0000_0013, 32'hFFFF_FFFF, 1'b0);
    accept_n(1);
    chk("al_addr", out_addr, 32'h84);
    chk("al_busy", 32'(busy), 32'h0);

    // Two compressed in one word
    do_clear(32'h100);
    push(32'h4501_4501, 1'b0);
    expect_insn(32'h100, 32'h4501, 32'hFFFF, 1'b0);
    expect_insn(32'h102, 32'h4501, 32'hFFFF, 1'b0);
    out_ready = 1'b1;
    cyc();
    chk("c2_busy_mid", 32'(busy), 32'h1);
    chk("c2_addr_mid", out_addr, 32'h102);
    cyc();
    out_ready = 1'b0;
    chk("c2_busy_end", 32'(busy), 32'h0);
    chk("c2_addr_end", out_addr, 32'h104);

    // Unaligned straddle, then trailing compressed
    do_clear(32'h202);
    push(32'h0013_0000, 1'b0);
    chk("ua_valid_wait", {31'b0, out_valid}, 32'h0);
    push(32'hABCD_0000, 1'b0);
    chk("ua_valid", {31'b0, out_valid}, 32'h1);
    expect_insn(32'h202, 32'h0000_0013, 32'hFFFF_FFFF, 1'b0);
    accept_n(1);
    chk("ua_addr", out_addr, 32'h206);
    chk("ua_busy", 32'(busy), 32'h1);
    expect_insn(32'h206, 32'hABCD, 32'hFFFF, 1'b0);
    accept_n(1);
    chk("ua_addr2", out_addr, 32'h208);
    chk("ua_busy2", 32'(busy), 32'h0);

    // Error on unaligned head: valid without second word
    do_clear(32'h302);
    push(32'h0003_0000, 1'b1);
    chk("er_valid", {31'b0, out_valid}, 32'h1);
    chk("er_err", {31'b0, out_err}, 32'h1);
    expect_insn(32'h302, 32'h0003, 32'hFFFF, 1'b1);
    accept_n(1);
    chk("er_addr", out_addr, 32'h306);

    // Full with simultaneous push and accept
    do_clear(32'h400);
    push(32'h0000_0013, 1'b0);
    push(32'h0010_0093, 1'b0);
    push(32'h0020_0113, 1'b0);
    chk("fu_busy", 32'(busy), 32'h7);
    expect_insn(32'h400, 32'h0000_0013, 32'hFFFF_FFFF, 1'b0);
    in_valid = 1'b1; in_rdata = 32'h0030_0193; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("fu_busy_pp", 32'(busy), 32'h7);
    expect_insn(32'h404, 32'h0010_0093, 32'hFFFF_FFFF, 1'b0);
    expect_insn(32'h408, 32'h0020_0113, 32'hFFFF_FFFF, 1'b0);
    expect_insn(32'h40C, 32'h0030_0193, 32'hFFFF_FFFF, 1'b0);
    accept_n(3);
    chk("fu_busy_end", 32'(busy), 32'h0);
    chk("fu_addr_end", out_addr, 32'h410);

    // Clear with same-cycle write; bit 0 of restart address dropped
    do_clear(32'h500);
    push(32'h0000_0013, 1'b0);
    clear = 1'b1; in_addr = 32'h601; in_valid = 1'b1; in_rdata = 32'hDEAD_BEEF;
    cyc();
    clear = 1'b0; in_valid = 1'b0;
    chk("cl_busy", 32'(busy), 32'h0);
    chk("cl_addr", out_addr, 32'h600);
    chk("cl_valid", {31'b0, out_valid}, 32'h0);

    // Reset mid-stream with write and accept pending
    push(32'h0000_0013, 1'b0);
    push(32'h0010_0093, 1'b0);
    rst = 1'b1; in_valid = 1'b1; in_rdata = 32'h0020_0113; out_ready = 1'b1;
    cyc();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_addr", out_addr, 32'h0);
    chk("mr_valid", {31'b0, out_valid}, 32'h0);
    chk("mr_rdata", out_rdata, 32'h0);

    // Address wrap-around
    do_clear(32'hFFFF_FFFC);
    push(32'h0000_0013, 1'b0);
    expect_insn(32'hFFFF_FFFC, 32'h0000_0013, 32'hFFFF_FFFF, 1'b0);
    accept_n(1);
    chk("wr_addr", out_addr, 32'h0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) cyc();
    chk("sb_drain", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
